// File: rtl/ifu_fetch.sv
// ifu_fetch: sequential instruction fetch with a credit-limited FIFO toward idu,
// handling alu redirects/flushes and WFI sleep.
module ifu_fetch #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_start,
    input  logic        ifu_wake,
    output logic        imem_req_vld,
    output logic [31:0] imem_req_addr,
    input  logic [63:0] imem_rsp_data,
    input  logic        idu_ifu_rdy,
    input  logic        idu_ifu_wfi,
    input  logic        alu_idu_flush_vld,
    input  logic [31:0] alu_ifu_redirect_pc,
    output logic        ifu_idu_vld,
    output logic [63:0] ifu_idu_ins,
    output logic [31:0] ifu_idu_pc,
    output logic        ifu_busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_WFI = 2'd2;
    logic [1:0]    state, state_nxt;
    logic [31:0]   fetch_pc, rsp_pc;
    logic          inflight, kill;
    logic [63:0]   ins_q [DEPTH];
    logic [31:0]   pc_q [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   cnt;
    logic [AW+1:0] occ;
    logic          run, empty, flush, pop, push;
    assign run   = state == S_RUN;
    assign empty = cnt == '0;
    assign flush = alu_idu_flush_vld;
    assign ifu_idu_vld = run & ~empty;
    assign pop   = ifu_idu_vld & idu_ifu_rdy & ~flush;
    assign push  = inflight & ~kill & ~flush;
    // Credits count both buffered and in-flight entries, so a push always has room.
    assign occ   = {1'b0, cnt} + (AW+2)'(inflight) - (AW+2)'(pop);
    assign imem_req_vld  = run & ~flush & (occ < (AW+2)'(DEPTH));
    assign imem_req_addr = fetch_pc;
    assign ifu_idu_ins   = empty ? '0 : ins_q[rd_ptr];
    assign ifu_idu_pc    = empty ? '0 : pc_q[rd_ptr];
    assign ifu_busy      = state != S_IDLE;
    always_comb begin
        state_nxt = state;
        if (state == S_IDLE && ifu_start) state_nxt = S_RUN;
        else if (run && idu_ifu_wfi && !flush) state_nxt = S_WFI;
        else if (state == S_WFI && ifu_wake) state_nxt = S_RUN;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            rsp_pc   <= '0;
            inflight <= 1'b0;
            kill     <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= imem_req_vld;
            kill     <= flush & inflight;
            if (imem_req_vld) rsp_pc <= fetch_pc;
            if (flush) begin
                fetch_pc <= alu_ifu_redirect_pc;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                cnt      <= '0;
            end else begin
                if (imem_req_vld) fetch_pc <= fetch_pc + PC_STEP;
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            ins_q[wr_ptr] <= imem_rsp_data;
            pc_q[wr_ptr]  <= rsp_pc;
        end
    end
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed scenarios for ifu_fetch against a 1-cycle SRAM model.
module tb_ifu_fetch;
    logic        clk = 0, rst = 1, ifu_start = 0, ifu_wake = 0;
    logic        idu_ifu_rdy = 0, idu_ifu_wfi = 0, alu_idu_flush_vld = 0;
    logic [31:0] alu_ifu_redirect_pc = '0;
    logic [63:0] imem_rsp_data = '0;
    logic        imem_req_vld, ifu_idu_vld, ifu_busy;
    logic [31:0] imem_req_addr, ifu_idu_pc;
    logic [63:0] ifu_idu_ins;
    int checks = 0, failures = 0;

    ifu_fetch dut (
        .clk(clk), .rst(rst), .ifu_start(ifu_start), .ifu_wake(ifu_wake),
        .imem_req_vld(imem_req_vld), .imem_req_addr(imem_req_addr), .imem_rsp_data(imem_rsp_data),
        .idu_ifu_rdy(idu_ifu_rdy), .idu_ifu_wfi(idu_ifu_wfi),
        .alu_idu_flush_vld(alu_idu_flush_vld), .alu_ifu_redirect_pc(alu_ifu_redirect_pc),
        .ifu_idu_vld(ifu_idu_vld), .ifu_idu_ins(ifu_idu_ins), .ifu_idu_pc(ifu_idu_pc),
        .ifu_busy(ifu_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mem(input logic [31:0] a);
        return {a ^ 32'hCAFE_F00D, ~a};
    endfunction

    // SRAM model: data for a request appears on the bus the following cycle.
    always @(posedge clk) imem_rsp_data <= imem_req_vld ? mem(imem_req_addr) : 64'h0BAD_0BAD_0BAD_0BAD;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic r, st, wk, rd, wf, fl, input logic [31:0] rp);
        @(negedge clk);
        rst = r; ifu_start = st; ifu_wake = wk; idu_ifu_rdy = rd;
        idu_ifu_wfi = wf; alu_idu_flush_vld = fl; alu_ifu_redirect_pc = rp;
        #1;
    endtask

    task automatic run1(); drv(0, 0, 0, 1, 0, 0, 0); endtask

    task automatic restart();
        drv(1, 0, 0, 1, 0, 0, 0);
        drv(0, 1, 0, 1, 0, 0, 0);
    endtask

    task automatic head(input string tag, input logic [31:0] pc);
        chk({tag, "_vld"}, 64'(ifu_idu_vld), 64'd1);
        chk({tag, "_pc"}, 64'(ifu_idu_pc), 64'(pc));
        chk({tag, "_ins"}, ifu_idu_ins, mem(pc));
    endtask

    task automatic req(input string tag, input logic [31:0] a);
        chk({tag, "_req"}, 64'(imem_req_vld), 64'd1);
        chk({tag, "_addr"}, 64'(imem_req_addr), 64'(a));
    endtask

    initial begin
        // Reset state and basic streaming with backpressure
        drv(1, 0, 0, 1, 0, 0, 0);
        drv(0, 0, 0, 1, 0, 0, 0);
        chk("rst_vld", 64'(ifu_idu_vld), 0);
        chk("rst_req", 64'(imem_req_vld), 0);
        chk("rst_busy", 64'(ifu_busy), 0);
        chk("rst_ins", ifu_idu_ins, 0);
        chk("rst_pc", 64'(ifu_idu_pc), 0);
        drv(0, 1, 0, 1, 0, 0, 0);
        chk("c0_req", 64'(imem_req_vld), 0);
        run1(); req("c1", 32'h0); chk("c1_busy", 64'(ifu_busy), 1);
        run1(); req("c2", 32'h8); chk("c2_vld", 64'(ifu_idu_vld), 0);
        run1(); req("c3", 32'h10); head("c3", 32'h0);
        run1(); req("c4", 32'h18); head("c4", 32'h8);
        for (int i = 0; i < 5; i++) begin
            drv(0, 0, 0, 0, 0, 0, 0);
            chk("stall_req", 64'(imem_req_vld), 0);
            head("stall", 32'h10);
        end
        run1(); req("c10", 32'h20); head("c10", 32'h10);
        run1(); req("c11", 32'h28); head("c11", 32'h18);
        run1(); head("c12", 32'h20);

        // Flush one cycle after the 0x18 request
        restart();
        repeat (4) run1();
        drv(0, 0, 0, 1, 0, 1, 32'h100);
        chk("fl1_req", 64'(imem_req_vld), 0);
        chk("fl1_pc", 64'(ifu_idu_pc), 64'h10);
        run1(); req("fl1_a", 32'h100); chk("fl1_vld_a", 64'(ifu_idu_vld), 0);
        run1(); req("fl1_b", 32'h108); chk("fl1_vld_b", 64'(ifu_idu_vld), 0);
        run1(); head("fl1_c", 32'h100);

        // Flush coincident with a handshake on pc 0x8
        restart();
        repeat (3) run1();
        drv(0, 0, 0, 1, 0, 1, 32'h200);
        head("fl2", 32'h8);
        chk("fl2_req", 64'(imem_req_vld), 0);
        run1(); req("fl2_a", 32'h200); chk("fl2_vld_a", 64'(ifu_idu_vld), 0);
        run1(); chk("fl2_vld_b", 64'(ifu_idu_vld), 0);
        run1(); head("fl2_c", 32'h200);

        // WFI with a request in flight
        restart();
        run1(); req("w1", 32'h0);
        drv(0, 0, 0, 1, 1, 0, 0); req("w2", 32'h8);
        run1();
        chk("w3_req", 64'(imem_req_vld), 0);
        chk("w3_vld", 64'(ifu_idu_vld), 0);
        chk("w3_busy", 64'(ifu_busy), 1);
        run1();
        chk("w4_req", 64'(imem_req_vld), 0);
        chk("w4_vld", 64'(ifu_idu_vld), 0);
        chk("w4_hold", 64'(ifu_idu_pc), 64'h0);
        drv(0, 0, 1, 1, 0, 0, 0);
        chk("w5_vld", 64'(ifu_idu_vld), 0);
        chk("w5_req", 64'(imem_req_vld), 0);
        run1(); head("w6", 32'h0); req("w6", 32'h10);
        run1(); head("w7", 32'h8); req("w7", 32'h18);
        run1(); head("w8", 32'h10);

        // Reset while credits are full and a request is issued
        restart();
        repeat (2) run1();
        drv(1, 0, 0, 1, 0, 0, 0);
        req("r3", 32'h10);
        run1();
        chk("r4_vld", 64'(ifu_idu_vld), 0);
        chk("r4_req", 64'(imem_req_vld), 0);
        chk("r4_busy", 64'(ifu_busy), 0);
        chk("r4_ins", ifu_idu_ins, 0);
        chk("r4_pc", 64'(ifu_idu_pc), 0);
        drv(0, 1, 0, 1, 0, 0, 0);
        chk("r5_ins", ifu_idu_ins, 0);
        chk("r5_pc", 64'(ifu_idu_pc), 0);
        run1(); req("r6", 32'h0);
        run1(); req("r7", 32'h8);
        run1(); head("r8", 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
